// File: rtl/twiddle_mul_1_0.sv
// Complex twiddle multiplier for 16 FFT lanes, placed between the stage-1 and stage-2 butterflies.
// Latency: 3 cycles (S1 operands+twiddle, S2 products, S3 round/saturate), one beat per cycle.
// No backpressure: valid_in gaps propagate unchanged and data registers hold their value across them.
module twiddle_mul_1_0 #(
    parameter int I_WIDTH    = 12,
    parameter int O_WIDTH    = 13,
    parameter int TW_WIDTH   = 9,
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_LEN  = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          valid_in,
    input  logic [DATA_WIDTH*I_WIDTH-1:0] din_re,
    input  logic [DATA_WIDTH*I_WIDTH-1:0] din_im,
    output logic [DATA_WIDTH*O_WIDTH-1:0] dout_re,
    output logic [DATA_WIDTH*O_WIDTH-1:0] dout_im,
    output logic                          valid_out,
    output logic                          frame_start_out
);

    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam int P_W   = I_WIDTH + TW_WIDTH;   // full-precision product
    localparam int S_W   = P_W + 1;              // sum of two products
    localparam int FRAC  = TW_WIDTH - 2;         // Q1.7 twiddles: 128 = +1.0

    localparam logic signed [S_W-1:0] RND_HALF = S_W'(1 << (FRAC - 1));
    localparam logic signed [S_W-1:0] SAT_HI   = S_W'((1 << (O_WIDTH - 1)) - 1);
    localparam logic signed [S_W-1:0] SAT_LO   = S_W'(-(1 << (O_WIDTH - 1)));

    // W(e) = cos(2*pi*e/64) - j*sin(2*pi*e/64), each component rounded from value*128.
    localparam logic signed [TW_WIDTH-1:0] TW_RE_ROM [0:63] = '{
         9'sd128,  9'sd127,  9'sd126,  9'sd122,  9'sd118,  9'sd113,  9'sd106,  9'sd99,
         9'sd91,   9'sd81,   9'sd71,   9'sd60,   9'sd49,   9'sd37,   9'sd25,   9'sd13,
         9'sd0,   -9'sd13,  -9'sd25,  -9'sd37,  -9'sd49,  -9'sd60,  -9'sd71,  -9'sd81,
        -9'sd91,  -9'sd99,  -9'sd106, -9'sd113, -9'sd118, -9'sd122, -9'sd126, -9'sd127,
        -9'sd128, -9'sd127, -9'sd126, -9'sd122, -9'sd118, -9'sd113, -9'sd106, -9'sd99,
        -9'sd91,  -9'sd81,  -9'sd71,  -9'sd60,  -9'sd49,  -9'sd37,  -9'sd25,  -9'sd13,
         9'sd0,    9'sd13,   9'sd25,   9'sd37,   9'sd49,   9'sd60,   9'sd71,   9'sd81,
         9'sd91,   9'sd99,   9'sd106,  9'sd113,  9'sd118,  9'sd122,  9'sd126,  9'sd127
    };
    localparam logic signed [TW_WIDTH-1:0] TW_IM_ROM [0:63] = '{
         9'sd0,   -9'sd13,  -9'sd25,  -9'sd37,  -9'sd49,  -9'sd60,  -9'sd71,  -9'sd81,
        -9'sd91,  -9'sd99,  -9'sd106, -9'sd113, -9'sd118, -9'sd122, -9'sd126, -9'sd127,
        -9'sd128, -9'sd127, -9'sd126, -9'sd122, -9'sd118, -9'sd113, -9'sd106, -9'sd99,
        -9'sd91,  -9'sd81,  -9'sd71,  -9'sd60,  -9'sd49,  -9'sd37,  -9'sd25,  -9'sd13,
         9'sd0,    9'sd13,   9'sd25,   9'sd37,   9'sd49,   9'sd60,   9'sd71,   9'sd81,
         9'sd91,   9'sd99,   9'sd106,  9'sd113,  9'sd118,  9'sd122,  9'sd126,  9'sd127,
         9'sd128,  9'sd127,  9'sd126,  9'sd122,  9'sd118,  9'sd113,  9'sd106,  9'sd99,
         9'sd91,   9'sd81,   9'sd71,   9'sd60,   9'sd49,   9'sd37,   9'sd25,   9'sd13
    };

    typedef struct packed {
        logic [I_WIDTH-1:0]  a;    // input real
        logic [I_WIDTH-1:0]  b;    // input imaginary
        logic [TW_WIDTH-1:0] c;    // twiddle real
        logic [TW_WIDTH-1:0] d;    // twiddle imaginary
    } s1_lane_t;

    typedef struct packed {
        logic [P_W-1:0] ac;
        logic [P_W-1:0] bd;
        logic [P_W-1:0] ad;
        logic [P_W-1:0] bc;
    } s2_lane_t;

    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [5:0]                         tw_idx;
    s1_lane_t [DATA_WIDTH-1:0]          s1_q, s1_d;
    logic                               s1_vld_q, s1_vld_d, s1_fs_q, s1_fs_d;
    s2_lane_t [DATA_WIDTH-1:0]          s2_q, s2_d;
    logic                               s2_vld_q, s2_vld_d, s2_fs_q, s2_fs_d;
    logic [DATA_WIDTH-1:0][O_WIDTH-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
    logic                               s3_vld_q, s3_vld_d, s3_fs_q, s3_fs_d;

    // Round half up at the Q1.7 binary point, then clamp to the output range.
    function automatic logic [O_WIDTH-1:0] rnd_sat(input logic signed [S_W-1:0] x);
        logic signed [S_W-1:0] r;
        logic [O_WIDTH-1:0]    y;
        r = (x + RND_HALF) >>> FRAC;
        if (r > SAT_HI) begin
            y = O_WIDTH'(SAT_HI);
        end else if (r < SAT_LO) begin
            y = O_WIDTH'(SAT_LO);
        end else begin
            y = O_WIDTH'(r);
        end
        return y;
    endfunction

    // In-frame beat counter: advances on valid beats only, wraps at the frame length.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_in) begin
            if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // S1: capture operands and look up the twiddle; add-path beats (cnt[1]=0) use W(0) = 1.
    always_comb begin
        s1_d     = s1_q;
        s1_vld_d = valid_in;
        s1_fs_d  = valid_in && (cnt_q == '0);
        tw_idx   = '0;
        if (valid_in) begin
            for (int k = 0; k < DATA_WIDTH; k++) begin
                tw_idx     = cnt_q[1] ? 6'(k * int'(cnt_q >> 2)) : 6'd0;
                s1_d[k].a  = din_re[k*I_WIDTH +: I_WIDTH];
                s1_d[k].b  = din_im[k*I_WIDTH +: I_WIDTH];
                s1_d[k].c  = TW_RE_ROM[tw_idx];
                s1_d[k].d  = TW_IM_ROM[tw_idx];
            end
        end
    end

    // S2: the four full-precision partial products per lane.
    always_comb begin
        s2_d     = s2_q;
        s2_vld_d = s1_vld_q;
        s2_fs_d  = s1_fs_q;
        if (s1_vld_q) begin
            for (int k = 0; k < DATA_WIDTH; k++) begin
                s2_d[k].ac = P_W'($signed(s1_q[k].a)) * P_W'($signed(s1_q[k].c));
                s2_d[k].bd = P_W'($signed(s1_q[k].b)) * P_W'($signed(s1_q[k].d));
                s2_d[k].ad = P_W'($signed(s1_q[k].a)) * P_W'($signed(s1_q[k].d));
                s2_d[k].bc = P_W'($signed(s1_q[k].b)) * P_W'($signed(s1_q[k].c));
            end
        end
    end

    // S3: re = ac - bd, im = ad + bc, widened by one bit before rounding and saturation.
    always_comb begin
        s3_re_d  = s3_re_q;
        s3_im_d  = s3_im_q;
        s3_vld_d = s2_vld_q;
        s3_fs_d  = s2_fs_q;
        if (s2_vld_q) begin
            for (int k = 0; k < DATA_WIDTH; k++) begin
                s3_re_d[k] = rnd_sat(S_W'($signed(s2_q[k].ac)) - S_W'($signed(s2_q[k].bd)));
                s3_im_d[k] = rnd_sat(S_W'($signed(s2_q[k].ad)) + S_W'($signed(s2_q[k].bc)));
            end
        end
    end

    // State registers; reset clears the counter, all valids and all pipeline data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            s1_fs_q  <= 1'b0;
            s2_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_fs_q  <= 1'b0;
            s3_re_q  <= '0;
            s3_im_q  <= '0;
            s3_vld_q <= 1'b0;
            s3_fs_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            s1_fs_q  <= s1_fs_d;
            s2_q     <= s2_d;
            s2_vld_q <= s2_vld_d;
            s2_fs_q  <= s2_fs_d;
            s3_re_q  <= s3_re_d;
            s3_im_q  <= s3_im_d;
            s3_vld_q <= s3_vld_d;
            s3_fs_q  <= s3_fs_d;
        end
    end

    assign dout_re         = s3_re_q;
    assign dout_im         = s3_im_q;
    assign valid_out       = s3_vld_q;
    assign frame_start_out = s3_fs_q;

endmodule

// File: tb/tb_twiddle_mul_1_0.sv
// Bench for twiddle_mul_1_0: hand-derived lane vectors plus a per-cycle scoreboard
// fed by a real-arithmetic reference (cos/sin twiddles, floor rounding, clamping).
// Outputs are sampled on the falling edge; inputs change right after it.
module tb_twiddle_mul_1_0;
    localparam int IW = 12;
    localparam int OW = 13;
    localparam int NL = 16;
    localparam int BL = 32;
    localparam int NV = 9;
    localparam real PI = 3.141592653589793;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid_in = 1'b0;
    logic [NL*IW-1:0] din_re = '0;
    logic [NL*IW-1:0] din_im = '0;
    logic [NL*OW-1:0] dout_re, dout_im;
    logic valid_out, frame_start_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    twiddle_mul_1_0 dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .din_re(din_re), .din_im(din_im),
        .dout_re(dout_re), .dout_im(dout_im),
        .valid_out(valid_out), .frame_start_out(frame_start_out)
    );

    typedef struct packed {
        logic vld;
        logic fs;
        logic [NL*OW-1:0] re;
        logic [NL*OW-1:0] im;
    } exp_t;

    typedef struct {
        int lane; int n; int a; int b; int er; int ei;
    } vec_t;

    exp_t pipe[$];
    logic [NL*OW-1:0] last_re, last_im;
    int n_model;
    vec_t vecs[NV];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [NL*OW-1:0] act, input logic [NL*OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic int tw_c(input int e);
        return $rtoi($floor(128.0 * $cos(2.0 * PI * e / 64.0) + 0.5));
    endfunction

    function automatic int tw_d(input int e);
        return $rtoi($floor(-128.0 * $sin(2.0 * PI * e / 64.0) + 0.5));
    endfunction

    function automatic int floor_div128(input int x);
        return (x >= 0) ? (x / 128) : -((-x + 127) / 128);
    endfunction

    function automatic int round_sat(input int x);
        int r;
        r = floor_div128(x + 64);
        if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
        if (r < -(1 << (OW - 1))) r = -(1 << (OW - 1));
        return r;
    endfunction

    // Expected output for the beat being driven now; invalid beats expect held data.
    task automatic push_expect(input logic v);
        exp_t x;
        x.vld = v;
        x.fs  = 1'b0;
        x.re  = last_re;
        x.im  = last_im;
        if (v) begin
            x.fs = (n_model == 0);
            for (int k = 0; k < NL; k++) begin
                int a, b, c, d, e, r, i;
                a = int'($signed(din_re[k*IW +: IW]));
                b = int'($signed(din_im[k*IW +: IW]));
                e = (((n_model / 2) % 2) == 1) ? ((k * (n_model / 4)) % 64) : 0;
                c = tw_c(e);
                d = tw_d(e);
                r = round_sat(a * c - b * d);
                i = round_sat(a * d + b * c);
                x.re[k*OW +: OW] = OW'(r);
                x.im[k*OW +: OW] = OW'(i);
            end
            last_re = x.re;
            last_im = x.im;
            n_model = (n_model + 1) % BL;
        end
        pipe.push_back(x);
    endtask

    task automatic prime();
        exp_t z;
        z = '0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        last_re = '0;
        last_im = '0;
        n_model = 0;
    endtask

    // One clock: drive, advance, compare against the beat driven three cycles ago.
    task automatic step(input logic v);
        exp_t x;
        valid_in = v;
        push_expect(v);
        @(posedge clk);
        @(negedge clk);
        if (pipe.size() > 0) begin
            x = pipe.pop_front();
            check_bit("valid_out", valid_out, x.vld);
            check_bit("frame_start_out", frame_start_out, x.fs);
            check_vec("dout_re", dout_re, x.re);
            check_vec("dout_im", dout_im, x.im);
        end
    endtask

    task automatic check_zero(input string tag);
        check_bit({tag, "_valid_out"}, valid_out, 1'b0);
        check_bit({tag, "_frame_start_out"}, frame_start_out, 1'b0);
        check_vec({tag, "_dout_re"}, dout_re, '0);
        check_vec({tag, "_dout_im"}, dout_im, '0);
    endtask

    // Assert reset asynchronously, confirm outputs clear at once and stay clear.
    task automatic do_reset(input int hold);
        valid_in = 1'b0;
        rstn = 1'b0;
        #1;
        check_zero("rst_now");
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        rstn = 1'b1;
        prime();
    endtask

    task automatic rand_din();
        for (int k = 0; k < NL; k++) begin
            case ($urandom_range(0, 7))
                0: din_re[k*IW +: IW] = {1'b1, {(IW-1){1'b0}}};
                1: din_re[k*IW +: IW] = {1'b0, {(IW-1){1'b1}}};
                default: din_re[k*IW +: IW] = IW'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: din_im[k*IW +: IW] = {1'b1, {(IW-1){1'b0}}};
                1: din_im[k*IW +: IW] = {1'b0, {(IW-1){1'b1}}};
                default: din_im[k*IW +: IW] = IW'($urandom);
            endcase
        end
    endtask

    // Reset, walk the counter to beat n with zero data, then drive one lane and read it back.
    task automatic run_vec(input int i);
        int got;
        do_reset(1);
        din_re = '0;
        din_im = '0;
        for (int j = 0; j < vecs[i].n; j++) step(1'b1);
        din_re[vecs[i].lane*IW +: IW] = IW'(vecs[i].a);
        din_im[vecs[i].lane*IW +: IW] = IW'(vecs[i].b);
        step(1'b1);
        din_re = '0;
        din_im = '0;
        step(1'b0);
        step(1'b0);
        got = int'($signed(dout_re[vecs[i].lane*OW +: OW]));
        check_int("vec_re", i, got, vecs[i].er);
        got = int'($signed(dout_im[vecs[i].lane*OW +: OW]));
        check_int("vec_im", i, got, vecs[i].ei);
    endtask

    initial begin
        //           lane  n     a      b      re     im
        vecs[0] = '{ 4,   6,   1000,     0,   922,  -383};  // e=4,  W=(118,-49)
        vecs[1] = '{ 8,  22,      0,  2047, -1455, -1455};  // e=40, W=(-91,91)
        vecs[2] = '{ 3,   2,  -2048,  2047, -2048,  2047};  // subtract beat, e=0
        vecs[3] = '{ 5,   0,   2047, -2048,  2047, -2048};  // add beat
        vecs[4] = '{15,  31,  -2048, -2048,  2880,  -288};  // e=105 mod 64 = 41
        vecs[5] = '{ 1,   7,    300,  -700,   227,  -725};  // e=1,  W=(127,-13)
        vecs[6] = '{12,  14,   2047,  2047, -2671, -1103};  // e=36, W=(-118,49)
        vecs[7] = '{ 6,   9,  -1234,   567, -1234,   567};  // add beat
        vecs[8] = '{ 1,  31,  -2048,  2047,  -289,  2879};  // e=7,  W=(99,-81)

        repeat (2) @(negedge clk);
        do_reset(2);

        // Full frame of constant (100,-50) on every lane.
        for (int k = 0; k < NL; k++) begin
            din_re[k*IW +: IW] = IW'(100);
            din_im[k*IW +: IW] = IW'(-50);
        end
        repeat (BL) step(1'b1);
        repeat (4) step(1'b0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Gapped traffic, pattern 1,0,0 repeating, 32 valid beats.
        do_reset(1);
        for (int c = 0; c < 3 * BL; c++) begin
            rand_din();
            step(c % 3 == 0);
        end
        repeat (3) step(1'b0);

        // Reset in the middle of a frame, then a clean frame.
        do_reset(1);
        for (int c = 0; c < 17; c++) begin
            rand_din();
            step(1'b1);
        end
        do_reset(3);
        for (int c = 0; c < BL; c++) begin
            rand_din();
            step(1'b1);
        end
        repeat (3) step(1'b0);

        // Random traffic: gaps, partial frames and several wraps.
        for (int c = 0; c < 400; c++) begin
            rand_din();
            step($urandom_range(0, 3) != 0);
        end
        repeat (3) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
